fir_row_feeder: RTL and testbench

- Transmit-side front end for the 3x3 RGB FIR/CNN core; the core is the receiver.
- Loads the 9 signed filter taps into the core over the tc_set/tc_data interface.
- Converts a single raster-order 24-bit pixel stream into three vertically aligned row streams (rows r-2, r-1, r) qualified by valid_dmac.
- Sits between the image DMA and fir_filter_CNN, replacing bench-side row tripling.

---
 rtl/fir_row_feeder.sv | 173 +++++++++++++++++
 tb/tb_fir_row_feeder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_row_feeder.sv
// Transmit-side front end for the 3x3 FIR/CNN core: loads the nine filter taps,
// then turns one raster pixel stream into three vertically aligned row streams.
module fir_row_feeder #(
    parameter int COL   = 320,
    parameter int ROW   = 320,
    parameter int PIX_W = 24,
    parameter int TAP_N = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tap_wr,
    input  logic [3:0]       tap_addr,
    input  logic [7:0]       tap_wdata,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             tc_set,
    output logic [23:0]      tc_data,
    output logic [PIX_W-1:0] input_data0,
    output logic [PIX_W-1:0] input_data1,
    output logic [PIX_W-1:0] input_data2,
    output logic             valid_dmac,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(COL);
    localparam int RW = $clog2(ROW);
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
    localparam logic [3:0]    TAP_LAST = 4'(TAP_N - 1);

    typedef enum logic [2:0] {IDLE, LOAD_TAPS, GAP, FILL, STREAM} state_e;

    state_e           state_q, state_d;
    logic [3:0]       tapIdx_q, tapIdx_d;
    logic             gapCnt_q, gapCnt_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PIX_W-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic             pixValid_q, pixValid_d;
    logic             frameDone_q, frameDone_d;
    logic [7:0]       tap_q [TAP_N];
    logic [PIX_W-1:0] lbA [COL];
    logic [PIX_W-1:0] lbB [COL];

    logic accept;
    logic loadPhase;
    logic colLast;

    assign pix_ready   = (state_q == FILL) || (state_q == STREAM);
    assign accept      = pix_valid && pix_ready;
    assign loadPhase   = (state_q == LOAD_TAPS);
    assign colLast     = (col_q == COL_LAST);
    assign tc_set      = loadPhase;
    assign tc_data     = loadPhase ? {3{tap_q[tapIdx_q]}} : 24'd0;
    assign valid_dmac  = loadPhase || pixValid_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = frameDone_q;
    assign input_data0 = d0_q;
    assign input_data1 = d1_q;
    assign input_data2 = d2_q;

    always_comb begin
        state_d     = state_q;
        tapIdx_d    = tapIdx_q;
        gapCnt_d    = gapCnt_q;
        col_d       = col_q;
        row_d       = row_q;
        d0_d        = d0_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        pixValid_d  = 1'b0;
        frameDone_d = 1'b0;

        if (accept) begin
            if (colLast) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD_TAPS;
                    tapIdx_d = '0;
                    col_d    = '0;
                    row_d    = '0;
                    d0_d     = '0;
                    d1_d     = '0;
                    d2_d     = '0;
                end
            end
            LOAD_TAPS: begin
                if (tapIdx_q == TAP_LAST) begin
                    state_d  = GAP;
                    gapCnt_d = 1'b0;
                end else begin
                    tapIdx_d = tapIdx_q + 1'b1;
                end
            end
            GAP: begin
                if (gapCnt_q) state_d = FILL;
                else          gapCnt_d = 1'b1;
            end
            FILL: begin
                if (accept && colLast && (row_q == RW'(1))) state_d = STREAM;
            end
            STREAM: begin
                // Buffers are read here before the same-address write lands at this edge.
                if (accept) begin
                    d0_d       = lbA[col_q];
                    d1_d       = lbB[col_q];
                    d2_d       = pix_in;
                    pixValid_d = 1'b1;
                    if (colLast && (row_q == ROW_LAST)) begin
                        state_d     = IDLE;
                        frameDone_d = 1'b1;
                        row_d       = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tapIdx_q    <= '0;
            gapCnt_q    <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            d0_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            pixValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tapIdx_q    <= tapIdx_d;
            gapCnt_q    <= gapCnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            pixValid_q  <= pixValid_d;
            frameDone_q <= frameDone_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAP_N; i++) tap_q[i] <= '0;
        end else if (tap_wr && (tap_addr < 4'(TAP_N))) begin
            tap_q[tap_addr] <= tap_wdata;
        end
    end

    // Line buffers shift one row down per accepted pixel; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lbA[col_q] <= lbB[col_q];
            lbB[col_q] <= pix_in;
        end
    end

endmodule

// File: tb/tb_fir_row_feeder.sv
// Directed bench for fir_row_feeder on a reduced frame, with a scoreboard of
// expected row-aligned output beats.
module tb_fir_row_feeder;

    localparam int COL   = 8;
    localparam int ROW   = 6;
    localparam int PIX_W = 24;
    localparam int TAP_N = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tap_wr;
    logic [3:0]       tap_addr;
    logic [7:0]       tap_wdata;
    logic             start;
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic             tc_set;
    logic [23:0]      tc_data;
    logic [PIX_W-1:0] input_data0, input_data1, input_data2;
    logic             valid_dmac;
    logic             busy;
    logic             frame_done;

    fir_row_feeder #(.COL(COL), .ROW(ROW), .PIX_W(PIX_W), .TAP_N(TAP_N)) dut (
        .clk(clk), .rst_n(rst_n), .tap_wr(tap_wr), .tap_addr(tap_addr),
        .tap_wdata(tap_wdata), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .tc_set(tc_set), .tc_data(tc_data),
        .input_data0(input_data0), .input_data1(input_data1), .input_data2(input_data2),
        .valid_dmac(valid_dmac), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d0;
        logic [23:0] d1;
        logic [23:0] d2;
        logic        last;
    } beat_t;

    beat_t      sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] tapModel [TAP_N];
    logic [7:0] loadSnap [TAP_N];
    int         pixIdx = 0;
    logic       frameActive = 1'b0;
    logic       expValidNext = 1'b0;
    int         beatsSeen = 0;
    int         doneSeen = 0;

    function automatic logic [23:0] pat(input int r, input int c);
        return 24'((r << 12) | c);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic writeTap(input logic [3:0] idx, input logic [7:0] val);
        @(posedge clk); #1;
        tap_wr = 1'b1; tap_addr = idx; tap_wdata = val;
        if (idx < TAP_N) tapModel[idx] = val;
        @(posedge clk); #1;
        tap_wr = 1'b0;
    endtask

    task automatic loadTaps(input int wrIdx, input logic [7:0] wrVal);
        for (int i = 0; i < TAP_N; i++) loadSnap[i] = tapModel[i];
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < TAP_N; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            tap_wr = 1'b0;
            if (i == wrIdx) begin
                tap_wr = 1'b1; tap_addr = 4'(i); tap_wdata = wrVal;
                tapModel[i] = wrVal;
            end
            @(negedge clk);
            checkOutput("tc_set beat", tc_set, 1);
            checkOutput($sformatf("tap beat %0d", i), tc_data, {3{loadSnap[i]}});
            checkOutput("valid on tap beat", valid_dmac, 1);
        end
        for (int g = 0; g < 2; g++) begin
            @(posedge clk); #1;
            tap_wr = 1'b0;
            @(negedge clk);
            checkOutput("gap valid", valid_dmac, 0);
            checkOutput("gap tc_set", tc_set, 0);
            checkOutput("gap tc_data", tc_data, 0);
            checkOutput("gap data0", input_data0, 0);
        end
        frameActive  = 1'b1;
        pixIdx       = 0;
        expValidNext = 1'b0;
    endtask

    task automatic stepPixel(input logic v, input logic inject);
        int r, c;
        logic [23:0] p;
        beat_t b;
        r = pixIdx / COL;
        c = pixIdx % COL;
        p = v ? pat(r, c) : 24'hDEAD00;
        @(posedge clk); #1;
        pix_valid = v; pix_in = p;
        start = inject;
        tap_wr = inject; tap_addr = 4'd0; tap_wdata = 8'h55;
        if (inject) tapModel[0] = 8'h55;
        @(negedge clk);
        checkOutput("pix_ready", pix_ready, frameActive);
        checkOutput("valid_dmac", valid_dmac, expValidNext);
        if (valid_dmac === 1'b1 && sb.size() > 0) begin
            b = sb.pop_front();
            checkOutput("data0", input_data0, b.d0);
            checkOutput("data1", input_data1, b.d1);
            checkOutput("data2", input_data2, b.d2);
            checkOutput("frame_done", frame_done, b.last);
            beatsSeen++;
            if (frame_done === 1'b1) doneSeen++;
        end else begin
            checkOutput("frame_done idle", frame_done, 0);
        end
        expValidNext = 1'b0;
        if (v && frameActive) begin
            if (pixIdx >= 2 * COL) begin
                sb.push_back('{pat(r - 2, c), pat(r - 1, c), p, (pixIdx == ROW * COL - 1)});
                expValidNext = 1'b1;
            end
            pixIdx++;
            if (pixIdx == ROW * COL) frameActive = 1'b0;
        end
    endtask

    task automatic runFrame(input logic stall, input logic injectMisc);
        int beats0, done0;
        beats0 = beatsSeen;
        done0  = doneSeen;
        for (int k = 0; k < 4 * ROW * COL && frameActive; k++) begin
            stepPixel(stall ? ((k % 2) == 0) : 1'b1,
                      injectMisc && (pixIdx == 3 * COL + 2) && !stall);
        end
        stepPixel(1'b0, 1'b0);
        checkOutput("frame bound", frameActive, 0);
        checkOutput("beat count", beatsSeen - beats0, (ROW - 2) * COL);
        checkOutput("frame_done count", doneSeen - done0, 1);
        checkOutput("busy after frame", busy, 0);
        checkOutput("scoreboard empty", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; tap_wr = 1'b0; tap_addr = '0; tap_wdata = '0;
        start = 1'b0; pix_in = '0; pix_valid = 1'b0;
        for (int i = 0; i < TAP_N; i++) tapModel[i] = '0;
        #12;
        checkOutput("reset valid", valid_dmac, 0);
        checkOutput("reset tc_set", tc_set, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset ready", pix_ready, 0);
        checkOutput("reset data0", input_data0, 0);
        checkOutput("reset frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < TAP_N; i++)
            writeTap(4'(i), ((i % 2) == 0) ? 8'(i + 1) : 8'(-(i + 1)));
        writeTap(4'd12, 8'h77);

        stepPixel(1'b1, 1'b0);
        stepPixel(1'b1, 1'b0);
        loadTaps(-1, 8'h00);
        runFrame(1'b0, 1'b1);

        stepPixel(1'b1, 1'b0);
        loadTaps(3, 8'h33);
        runFrame(1'b1, 1'b0);

        loadTaps(-1, 8'h00);
        for (int k = 0; k < 4 * COL; k++) stepPixel(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset valid", valid_dmac, 0);
        checkOutput("midreset tc_set", tc_set, 0);
        checkOutput("midreset tc_data", tc_data, 0);
        checkOutput("midreset data0", input_data0, 0);
        checkOutput("midreset data1", input_data1, 0);
        checkOutput("midreset data2", input_data2, 0);
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset ready", pix_ready, 0);
        sb.delete();
        for (int i = 0; i < TAP_N; i++) tapModel[i] = '0;
        frameActive = 1'b0; expValidNext = 1'b0; pixIdx = 0; pix_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < TAP_N; i++) writeTap(4'(i), 8'(8'hA0 + i));
        loadTaps(-1, 8'h00);
        runFrame(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
